control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Moore-style controller FSM for the multi-cycle processor. Sits between the program counter and the instruction ROM on one side, and the register file, data RAM and ALU on the other.
- Drives pc_clr and pc_up into the program counter and latches the ROM word at the current address into an internal instruction register.
- Decodes that word and sequences the datapath control lines through fetch, decode and execute states.

Parameters:
- DATA_ADDR_W, 8, data RAM address width
- REG_ADDR_W, 4, register file address width
- ALU_SEL_W, 3, ALU function select width
- INSTR_W, 16, instruction width; fixed field layout below

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- instr  in  INSTR_W  ROM read data at the current PC address (combinational ROM read)
- pc_clr  out  1  synchronous clear to program counter
- pc_up  out  1  increment program counter
- d_addr  out  DATA_ADDR_W  data RAM address
- d_wr  out  1  data RAM write enable
- rf_s  out  1  register write-data mux: 1 = RAM data, 0 = ALU result
- rf_w_addr  out  REG_ADDR_W  register write address
- rf_w_en  out  1  register write enable
- rf_ra_addr  out  REG_ADDR_W  register read port A address
- rf_rb_addr  out  REG_ADDR_W  register read port B address
- alu_s0  out  ALU_SEL_W  ALU select: 0 = pass A, 1 = A+B, 2 = A-B
- state  out  4  current state encoding, for debug and display
- halted  out  1  1 while in HALT

Behaviour:
- Instruction format: opcode = [15:12].
  - NOOP 0000
  - STORE 0001: Ra = [11:8], D_addr = [7:0]
  - LOAD 0010: D_addr = [11:4], Rw = [3:0]
  - ADD 0011 and SUB 0100: Ra = [11:8], Rb = [7:4], Rw = [3:0]
  - HALT 0101
  - Opcodes 0110..1111 execute as NOOP.
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Reset (clear = 0, any time, including mid-instruction):
  - state goes to INIT and the IR goes to 0 immediately.
  - Every output is 0 except pc_clr, which is 1 because INIT asserts it.
- INIT: pc_clr = 1 for one cycle, then go to FETCH.
- FETCH: pc_up = 1 and the IR loads instr on the same edge. The IR holds the word at the old PC value, and the PC increments. Then go to DECODE.
- DECODE: all enables are 0. The field outputs are already driven from the IR. Branch on opcode.
- NOOP: all enables are 0. Go to FETCH.
- STORE: d_addr = IR[7:0], rf_ra_addr = IR[11:8], alu_s0 = 0, d_wr = 1 for exactly one cycle. Go to FETCH.
- LOAD_A: d_addr = IR[11:4], rf_s = 1, rf_w_addr = IR[3:0], rf_w_en = 0. This cycle covers the synchronous RAM read.
- LOAD_B: same as LOAD_A but with rf_w_en = 1. Go to FETCH.
- ADD and SUB: rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], rf_w_addr = IR[3:0], rf_s = 0, rf_w_en = 1. alu_s0 = 1 for ADD, 2 for SUB. Go to FETCH.
- HALT: halted = 1 and all enables are 0. Stays in HALT until clear is asserted. pc_up is never asserted here.
- Instruction latency:
  - NOOP, STORE, ADD, SUB: 3 cycles (FETCH, DECODE, exec).
  - LOAD: 4 cycles.
- Output rules:
  - All outputs are a pure function of state and IR. There are no combinational paths from instr.
  - Enables (pc_up, pc_clr, d_wr, rf_w_en) are 0 in every state not listed for them.
  - In states with no named use, the address outputs carry IR fields and have no effect.
- PC wrap: after the last ROM address the program counter wraps to 0. The controller does not detect this; programs terminate with HALT.
- Illegal state encodings go to INIT on the next edge.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_NOOP..OP_HALT
  - state encodings S_INIT..S_HALT
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB
  - field bit-position constants
- One sub-module, instruction_register: INSTR_W-bit register with load enable and the same asynchronous active-low clear.
- The FSM and decode logic stay in control_unit.

Test Plan:
- Reset and start: hold clear = 0 for 3 cycles, then release. Required:
  - pc_clr = 1 during reset.
  - The first cycle after release is INIT with pc_clr = 1.
  - The next cycle is FETCH with pc_up = 1.
- ADD: instr = 16'h3125. Required:
  - FETCH, DECODE, then ADD.
  - In ADD: rf_ra_addr = 1, rf_rb_addr = 2, rf_w_addr = 5, alu_s0 = 1, rf_w_en = 1, rf_s = 0.
  - Then back to FETCH.
- LOAD: instr = 16'h2A73. Required:
  - LOAD_A: d_addr = 8'hA7, rf_w_addr = 3, rf_s = 1, rf_w_en = 0.
  - LOAD_B: same values with rf_w_en = 1.
- STORE and SUB: instr = 16'h14C8. Required: d_addr = 8'hC8, rf_ra_addr = 4, d_wr = 1 for exactly 1 cycle. Then instr = 16'h4F01. Required: alu_s0 = 2, rf_w_addr = 1.
- HALT: instr = 16'h5000. Required:
  - halted = 1 and pc_up = 0 for more than 10 cycles.
  - After a clear pulse, the sequence restarts from INIT.
- Mid-op reset and illegal opcode:
  - Assert clear during LOAD_A. Required: state goes to INIT asynchronously with rf_w_en = 0, and no LOAD_B follows.
  - Apply instr = 16'hF123. Required: it executes as NOOP with all enables 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle processor controller: opcodes,
// FSM state encodings, ALU selects and instruction field bit positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;
    localparam int RA_MSB      = 11;
    localparam int RA_LSB      = 8;
    localparam int RB_MSB      = 7;
    localparam int RB_LSB      = 4;
    localparam int RW_MSB      = 3;
    localparam int RW_LSB      = 0;
    localparam int ST_ADDR_MSB = 7;
    localparam int ST_ADDR_LSB = 0;
    localparam int LD_ADDR_MSB = 11;
    localparam int LD_ADDR_LSB = 4;

endpackage

// File: rtl/instruction_register.sv
// Instruction register: holds the ROM word captured during FETCH.
// Ports: clock, clear (async active-low), load (capture enable),
//        d (ROM word), q (held instruction).
module instruction_register #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore controller for the multi-cycle processor. Steps the program counter,
// captures the ROM word into the instruction register and sequences the
// register file, data RAM and ALU controls.
// Ports: clock, clear (async active-low), instr (ROM word at current PC);
//        pc_clr/pc_up to the PC; d_addr/d_wr to data RAM; rf_s, rf_w_addr,
//        rf_w_en, rf_ra_addr, rf_rb_addr to the register file; alu_s0 to the
//        ALU; state and halted for debug/display.
//
// state  | meaning
// INIT   | clear the program counter
// FETCH  | capture instruction, advance PC
// DECODE | fields visible on outputs, branch on opcode
// NOOP   | idle one cycle (also all unused opcodes)
// LOAD_A | RAM read cycle, write-back mux selects RAM
// LOAD_B | write RAM data into register file
// STORE  | write register A into RAM for one cycle
// ADD    | Rw <= Ra + Rb
// SUB    | Rw <= Ra - Rb
// HALT   | parked until clear
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_ADDR_W = 8,
    parameter int REG_ADDR_W  = 4,
    parameter int ALU_SEL_W   = 3,
    parameter int INSTR_W     = 16
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [INSTR_W-1:0]     instr,
    output logic                   pc_clr,
    output logic                   pc_up,
    output logic [DATA_ADDR_W-1:0] d_addr,
    output logic                   d_wr,
    output logic                   rf_s,
    output logic [REG_ADDR_W-1:0]  rf_w_addr,
    output logic                   rf_w_en,
    output logic [REG_ADDR_W-1:0]  rf_ra_addr,
    output logic [REG_ADDR_W-1:0]  rf_rb_addr,
    output logic [ALU_SEL_W-1:0]   alu_s0,
    output logic [3:0]             state,
    output logic                   halted
);

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic               ir_load;

    assign ir_load = (state_q == S_FETCH);

    instruction_register #(.WIDTH(INSTR_W)) u_ir (
        .clock (clock),
        .clear (clear),
        .load  (ir_load),
        .d     (instr),
        .q     (ir_q)
    );

    // Value the IR will hold after this edge; outputs are registered from
    // it so that DECODE already shows the new instruction's fields.
    assign ir_d = ir_load ? instr : ir_q;

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ir_q[OPC_MSB:OPC_LSB])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are decoded from the next state and next IR and registered,
    // so they are a function of (state, IR) with no path from instr.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_INIT;
            pc_clr     <= 1'b1;
            pc_up      <= 1'b0;
            d_addr     <= '0;
            d_wr       <= 1'b0;
            rf_s       <= 1'b0;
            rf_w_addr  <= '0;
            rf_w_en    <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
            alu_s0     <= '0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_clr     <= (state_d == S_INIT);
            pc_up      <= (state_d == S_FETCH);
            d_wr       <= (state_d == S_STORE);
            rf_s       <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            rf_w_en    <= (state_d == S_LOAD_B) || (state_d == S_ADD) ||
                          (state_d == S_SUB);
            halted     <= (state_d == S_HALT);
            if (state_d == S_ADD) begin
                alu_s0 <= ALU_ADD;
            end else if (state_d == S_SUB) begin
                alu_s0 <= ALU_SUB;
            end else begin
                alu_s0 <= ALU_PASS;
            end
            // LOAD and STORE place the RAM address in different fields.
            if (ir_d[OPC_MSB:OPC_LSB] == OP_LOAD) begin
                d_addr <= ir_d[LD_ADDR_MSB:LD_ADDR_LSB];
            end else begin
                d_addr <= ir_d[ST_ADDR_MSB:ST_ADDR_LSB];
            end
            rf_ra_addr <= ir_d[RA_MSB:RA_LSB];
            rf_rb_addr <= ir_d[RB_MSB:RB_LSB];
            rf_w_addr  <= ir_d[RW_MSB:RW_LSB];
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a small ROM + PC environment and a
// trace model that expands each program into the expected per-cycle outputs.
module tb_control_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] instr;
    logic        pc_clr, pc_up, d_wr, rf_s, rf_w_en, halted;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
    logic [2:0]  alu_s0;

    always #5 clock = ~clock;

    control_unit dut (
        .clock      (clock),
        .clear      (clear),
        .instr      (instr),
        .pc_clr     (pc_clr),
        .pc_up      (pc_up),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s0     (alu_s0),
        .state      (state),
        .halted     (halted)
    );

    logic [15:0] rom [16];
    logic [3:0]  pc;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)      pc <= '0;
        else if (pc_clr) pc <= '0;
        else if (pc_up)  pc <= pc + 4'd1;
    end

    assign instr = rom[pc];

    typedef struct {
        logic [3:0] st;
        logic       pclr, pup, dwr, wen, rfs, hlt;
        logic [2:0] alu;
        bit         cd; logic [7:0] da;
        bit         ca; logic [3:0] ra;
        bit         cb; logic [3:0] rb;
        bit         cw; logic [3:0] rw;
    } exp_t;

    exp_t trace[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e = '{default: 0};
        e.st = st;
        return e;
    endfunction

    function automatic logic [12:0] dut_ctl();
        return {state, pc_clr, pc_up, d_wr, rf_w_en, rf_s, halted, alu_s0};
    endfunction

    function automatic logic [12:0] exp_ctl(input exp_t e);
        return {e.st, e.pclr, e.pup, e.dwr, e.wen, e.rfs, e.hlt, e.alu};
    endfunction

    // Expand a program into the cycle-by-cycle behaviour it must produce.
    function automatic void build_trace(input logic [15:0] prog [16], input int halt_cycles);
        exp_t e;
        logic [15:0] w;
        trace.delete();
        e = blank(S_INIT); e.pclr = 1'b1; trace.push_back(e);
        for (int a = 0; a < 16; a++) begin
            w = prog[a];
            e = blank(S_FETCH); e.pup = 1'b1; trace.push_back(e);
            trace.push_back(blank(S_DECODE));
            case (w[15:12])
                4'h1: begin
                    e = blank(S_STORE); e.dwr = 1'b1;
                    e.cd = 1; e.da = w[7:0]; e.ca = 1; e.ra = w[11:8];
                    trace.push_back(e);
                end
                4'h2: begin
                    e = blank(S_LOAD_A); e.rfs = 1'b1;
                    e.cd = 1; e.da = w[11:4]; e.cw = 1; e.rw = w[3:0];
                    trace.push_back(e);
                    e.st = S_LOAD_B; e.wen = 1'b1;
                    trace.push_back(e);
                end
                4'h3, 4'h4: begin
                    e = blank(w[15:12] == 4'h3 ? S_ADD : S_SUB);
                    e.wen = 1'b1; e.alu = (w[15:12] == 4'h3) ? 3'd1 : 3'd2;
                    e.ca = 1; e.ra = w[11:8]; e.cb = 1; e.rb = w[7:4];
                    e.cw = 1; e.rw = w[3:0];
                    trace.push_back(e);
                end
                4'h5: begin
                    e = blank(S_HALT); e.hlt = 1'b1;
                    for (int k = 0; k < halt_cycles; k++) trace.push_back(e);
                    return;
                end
                default: trace.push_back(blank(S_NOOP));
            endcase
        end
    endfunction

    task automatic apply_reset(input string name);
        clear = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_eq({name, " in-reset"},
                     {dut_ctl(), d_addr, rf_ra_addr, rf_rb_addr, rf_w_addr},
                     {4'd0, 6'b100000, 3'd0, 8'd0, 12'd0});
        end
        @(posedge clock);
        #1 clear = 1'b1;
    endtask

    task automatic run_trace(input string name);
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clock);
            check_eq($sformatf("%s ctl c%0d", name, i), {27'd0, dut_ctl()}, {27'd0, exp_ctl(trace[i])});
            if (trace[i].cd) check_eq($sformatf("%s d_addr c%0d", name, i), {32'd0, d_addr}, {32'd0, trace[i].da});
            if (trace[i].ca) check_eq($sformatf("%s ra c%0d", name, i), {36'd0, rf_ra_addr}, {36'd0, trace[i].ra});
            if (trace[i].cb) check_eq($sformatf("%s rb c%0d", name, i), {36'd0, rf_rb_addr}, {36'd0, trace[i].rb});
            if (trace[i].cw) check_eq($sformatf("%s rw c%0d", name, i), {36'd0, rf_w_addr}, {36'd0, trace[i].rw});
        end
    endtask

    task automatic run_program(input logic [15:0] prog [16], input int halt_cycles, input string name);
        rom = prog;
        build_trace(prog, halt_cycles);
        apply_reset(name);
        run_trace(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] p [16];

        // Directed program covering every opcode class plus an illegal one.
        p = '{default: 16'h5000};
        p[0] = 16'h3125; p[1] = 16'h2A73; p[2] = 16'h14C8;
        p[3] = 16'h4F01; p[4] = 16'hF123; p[5] = 16'h5000;
        run_program(p, 12, "directed");

        // Clear asserted in the middle of a LOAD.
        p = '{default: 16'h5000};
        p[0] = 16'h2A73;
        rom = p;
        apply_reset("midop");
        repeat (4) @(negedge clock);
        check_eq("midop at LOAD_A", {36'd0, state}, {36'd0, 4'(S_LOAD_A)});
        #1 clear = 1'b0;
        #1;
        check_eq("midop async state", {36'd0, state}, {36'd0, 4'(S_INIT)});
        check_eq("midop rf_w_en", {39'd0, rf_w_en}, 40'd0);
        check_eq("midop pc_clr", {39'd0, pc_clr}, 40'd1);
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        check_eq("midop restart INIT", {27'd0, dut_ctl()}, {27'd0, 4'(S_INIT), 6'b100000, 3'd0});
        @(negedge clock);
        check_eq("midop then FETCH", {27'd0, dut_ctl()}, {27'd0, 4'(S_FETCH), 6'b010000, 3'd0});

        // Random programs, each terminated by HALT in the last slot at latest.
        for (int t = 0; t < 20; t++) begin
            int len;
            p = '{default: 16'h5000};
            len = $urandom_range(0, 14);
            for (int k = 0; k < len; k++) p[k] = 16'($urandom);
            run_program(p, 3, $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
